// File: rtl/flr_responder.sv
// FIM-side PCIe FLR responder. It queues FLR request pulses and drives a timed
// per-function reset for each one. It then waits for the port to drain and returns an in-order completion pulse.
module flr_responder #(
  parameter int FIFO_DEPTH    = 4,
  parameter int RST_CYCLES    = 16,
  parameter int DRAIN_TIMEOUT = 1024,
  parameter int PF_WIDTH      = 3,
  parameter int VF_WIDTH      = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flr_req_valid,
  input  logic [PF_WIDTH-1:0] flr_req_pf,
  input  logic [VF_WIDTH-1:0] flr_req_vf,
  input  logic                flr_req_vf_active,
  output logic                flr_rsp_valid,
  output logic [PF_WIDTH-1:0] flr_rsp_pf,
  output logic [VF_WIDTH-1:0] flr_rsp_vf,
  output logic                flr_rsp_vf_active,
  output logic                func_rst_valid,
  output logic [PF_WIDTH-1:0] func_rst_pf,
  output logic [VF_WIDTH-1:0] func_rst_vf,
  output logic                func_rst_vf_active,
  input  logic                afu_quiesced,
  output logic                busy,
  output logic                err_overflow,
  output logic                err_timeout,
  input  logic                err_clr
);
  // Handshake: flr_req_valid is a one-cycle pulse with no ready. A request that
  // meets a full queue with no pop in the same cycle is lost and flagged.
  // flr_rsp_valid is likewise a one-cycle pulse with no back-pressure.

  localparam int ID_W    = 1 + PF_WIDTH + VF_WIDTH;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_MAX = (RST_CYCLES > DRAIN_TIMEOUT) ? RST_CYCLES : DRAIN_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CNT_MAX);
  localparam logic [PTR_W:0]   DEPTH      = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_DRAIN   = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  state_t state, state_next;

  logic [ID_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   fifo_count, fifo_count_next;
  logic             fifo_full, fifo_empty;
  logic             push, pop, drop;
  logic [ID_W-1:0]  req_id, head_id;

  logic [CNT_W-1:0] cnt;
  logic [ID_W-1:0]  cur_id, cur_id_next;
  logic             timeout_hit;

  logic             rst_valid_d, rsp_valid_d, busy_d;
  logic [ID_W-1:0]  rst_id_d, rsp_id_d;

  // Queue of pending function IDs
  assign req_id     = {flr_req_vf_active, flr_req_pf, flr_req_vf};
  assign head_id    = fifo_mem[rd_ptr];
  assign fifo_full  = (fifo_count == DEPTH);
  assign fifo_empty = (fifo_count == '0);
  assign pop        = (state == S_IDLE) && !fifo_empty;
  assign push       = flr_req_valid && (!fifo_full || pop);
  assign drop       = flr_req_valid && fifo_full && !pop;

  always_comb begin
    fifo_count_next = fifo_count;
    if (push && !pop) begin
      fifo_count_next = fifo_count + 1'b1;
    end else if (pop && !push) begin
      fifo_count_next = fifo_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= req_id;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count_next;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM: next state. In DRAIN the counter is 0 in the first cycle, so the
  // forced response comes DRAIN_TIMEOUT cycles after that first drain cycle.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (!fifo_empty) state_next = S_ASSERT;
      S_ASSERT:  if (cnt == RST_LAST) state_next = S_DRAIN;
      S_DRAIN:   if (afu_quiesced || (cnt == DRAIN_LAST)) state_next = S_RESPOND;
      S_RESPOND: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Quiesce wins over a coincident timeout
  assign timeout_hit = (state == S_DRAIN) && !afu_quiesced && (cnt == DRAIN_LAST);
  assign cur_id_next = pop ? head_id : cur_id;

  always_ff @(posedge clk) begin
    if (reset || (state_next != state)) begin
      cnt <= '0;
    end else if (((state == S_ASSERT) || (state == S_DRAIN)) && (cnt != CNT_LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_id <= '0;
    end else begin
      cur_id <= cur_id_next;
    end
  end

  // FSM: outputs, computed from the next state so the registered copies line
  // up with the state they describe
  always_comb begin
    rst_valid_d = (state_next == S_ASSERT);
    rsp_valid_d = (state_next == S_RESPOND);
    rst_id_d    = rst_valid_d ? cur_id_next : '0;
    rsp_id_d    = rsp_valid_d ? cur_id : '0;
    busy_d      = (state_next != S_IDLE) || (fifo_count_next != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      func_rst_valid <= 1'b0;
      {func_rst_vf_active, func_rst_pf, func_rst_vf} <= '0;
      flr_rsp_valid  <= 1'b0;
      {flr_rsp_vf_active, flr_rsp_pf, flr_rsp_vf} <= '0;
      busy           <= 1'b0;
    end else begin
      func_rst_valid <= rst_valid_d;
      {func_rst_vf_active, func_rst_pf, func_rst_vf} <= rst_id_d;
      flr_rsp_valid  <= rsp_valid_d;
      {flr_rsp_vf_active, flr_rsp_pf, flr_rsp_vf} <= rsp_id_d;
      busy           <= busy_d;
    end
  end

  // Sticky errors; a new event beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      err_overflow <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      if (drop)         err_overflow <= 1'b1;
      else if (err_clr) err_overflow <= 1'b0;
      if (timeout_hit)  err_timeout  <= 1'b1;
      else if (err_clr) err_timeout  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_flr_responder.sv
// Directed bench for flr_responder: one instance with default parameters and
// a second one with DRAIN_TIMEOUT=8 for the timeout scenarios.
module tb_flr_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic [2:0]  req_pf = '0;
  logic [10:0] req_vf = '0;
  logic        req_vfa = 1'b0;
  logic        quiesced = 1'b0;
  logic        err_clr = 1'b0;
  logic        rsp_valid, rsp_vfa, rst_valid, rst_vfa, busy, err_ovf, err_to;
  logic [2:0]  rsp_pf, rst_pf;
  logic [10:0] rsp_vf, rst_vf;

  logic        t_req_valid = 1'b0;
  logic [2:0]  t_req_pf = '0;
  logic [10:0] t_req_vf = '0;
  logic        t_req_vfa = 1'b0;
  logic        t_quiesced = 1'b0;
  logic        t_err_clr = 1'b0;
  logic        t_rsp_valid, t_rsp_vfa, t_rst_valid, t_rst_vfa, t_busy, t_err_ovf, t_err_to;
  logic [2:0]  t_rsp_pf, t_rst_pf;
  logic [10:0] t_rsp_vf, t_rst_vf;

  int checks = 0;
  int errors = 0;

  logic [14:0] exp_q[$];
  int          exp_cyc_q[$];

  flr_responder dut (
    .clk(clk), .reset(reset),
    .flr_req_valid(req_valid), .flr_req_pf(req_pf), .flr_req_vf(req_vf),
    .flr_req_vf_active(req_vfa),
    .flr_rsp_valid(rsp_valid), .flr_rsp_pf(rsp_pf), .flr_rsp_vf(rsp_vf),
    .flr_rsp_vf_active(rsp_vfa),
    .func_rst_valid(rst_valid), .func_rst_pf(rst_pf), .func_rst_vf(rst_vf),
    .func_rst_vf_active(rst_vfa),
    .afu_quiesced(quiesced), .busy(busy),
    .err_overflow(err_ovf), .err_timeout(err_to), .err_clr(err_clr)
  );

  flr_responder #(.DRAIN_TIMEOUT(8)) dut_to (
    .clk(clk), .reset(reset),
    .flr_req_valid(t_req_valid), .flr_req_pf(t_req_pf), .flr_req_vf(t_req_vf),
    .flr_req_vf_active(t_req_vfa),
    .flr_rsp_valid(t_rsp_valid), .flr_rsp_pf(t_rsp_pf), .flr_rsp_vf(t_rsp_vf),
    .flr_rsp_vf_active(t_rsp_vfa),
    .func_rst_valid(t_rst_valid), .func_rst_pf(t_rst_pf), .func_rst_vf(t_rst_vf),
    .func_rst_vf_active(t_rst_vfa),
    .afu_quiesced(t_quiesced), .busy(t_busy),
    .err_overflow(t_err_ovf), .err_timeout(t_err_to), .err_clr(t_err_clr)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if ({rsp_valid, rsp_pf, rsp_vf, rsp_vfa, rst_valid, rst_pf, rst_vf, rst_vfa,
         busy, err_ovf, err_to} !== 34'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {rsp_valid, rsp_pf, rsp_vf, rsp_vfa,
               rst_valid, rst_pf, rst_vf, rst_vfa, busy, err_ovf, err_to});
    end
    checks++;
    if ({t_rsp_valid, t_rsp_pf, t_rsp_vf, t_rsp_vfa, t_rst_valid, t_rst_pf, t_rst_vf, t_rst_vfa,
         t_busy, t_err_ovf, t_err_to} !== 34'd0) begin
      errors++;
      $display("FAIL reset_outputs_to: got %h expected 0", {t_rsp_valid, t_rsp_pf, t_rsp_vf,
               t_rsp_vfa, t_rst_valid, t_rst_pf, t_rst_vf, t_rst_vfa, t_busy, t_err_ovf, t_err_to});
    end
    reset = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b expected 0", busy);
    end
  endtask

  // pf=2 PF reset with the port already quiesced: reset T+2..T+17, response T+19
  task automatic test_single();
    logic        exp_rv, exp_busy;
    logic [14:0] exp_rsp;
    quiesced = 1'b1;
    req_valid = 1'b1; req_pf = 3'd2; req_vf = '0; req_vfa = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      step();
      if (k == 1) begin
        req_valid = 1'b0; req_pf = '0;
      end
      exp_rv   = (k >= 2) && (k <= 17);
      exp_busy = (k >= 1) && (k <= 19);
      exp_rsp  = (k == 19) ? {1'b0, 3'd2, 11'd0} : 15'd0;
      checks++;
      if (rst_valid !== exp_rv || rst_pf !== (exp_rv ? 3'd2 : 3'd0) || rst_vf !== 11'd0 ||
          rst_vfa !== 1'b0) begin
        errors++;
        $display("FAIL single_func_rst at T+%0d: got valid=%b pf=%0d vf=%0d vfa=%b expected valid=%b pf=%0d",
                 k, rst_valid, rst_pf, rst_vf, rst_vfa, exp_rv, exp_rv ? 2 : 0);
      end
      checks++;
      if (rsp_valid !== (k == 19) || {rsp_vfa, rsp_pf, rsp_vf} !== exp_rsp) begin
        errors++;
        $display("FAIL single_rsp at T+%0d: got valid=%b id=%h expected valid=%b id=%h",
                 k, rsp_valid, {rsp_vfa, rsp_pf, rsp_vf}, (k == 19), exp_rsp);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL single_busy at T+%0d: got %b expected %b", k, busy, exp_busy);
      end
    end
    checks++;
    if (err_ovf !== 1'b0 || err_to !== 1'b0) begin
      errors++;
      $display("FAIL single_errors: got ovf=%b to=%b expected 0 0", err_ovf, err_to);
    end
  endtask

  // Five pulses VF 1..5 on consecutive cycles, quiesce from cycle 50. Each later
  // pop happens the cycle after RESPOND, then the usual 18-cycle pop-to-response path.
  task automatic test_back_to_back();
    logic [14:0] id;
    int          cyc;
    quiesced = 1'b0;
    exp_q.delete(); exp_cyc_q.delete();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({1'b1, 3'd0, 11'(i + 1)});
      exp_cyc_q.push_back(51 + 19 * i);
    end
    req_valid = 1'b1; req_pf = 3'd0; req_vfa = 1'b1; req_vf = 11'd1;
    for (int k = 1; k <= 135; k++) begin
      step();
      if (k < 5) req_vf = 11'(k + 1);
      else begin
        req_valid = 1'b0; req_vf = '0; req_vfa = 1'b0;
      end
      if (k == 50) quiesced = 1'b1;
      if (rsp_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_unexpected_rsp at cycle %0d: got id=%h expected none", k,
                   {rsp_vfa, rsp_pf, rsp_vf});
        end else begin
          id = exp_q.pop_front();
          cyc = exp_cyc_q.pop_front();
          if ({rsp_vfa, rsp_pf, rsp_vf} !== id || k != cyc) begin
            errors++;
            $display("FAIL b2b_rsp: got id=%h at cycle %0d expected id=%h at cycle %0d",
                     {rsp_vfa, rsp_pf, rsp_vf}, k, id, cyc);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_missing: got %0d responses outstanding expected 0", exp_q.size());
    end
    checks++;
    if (err_ovf !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_final: got ovf=%b busy=%b expected 0 0", err_ovf, busy);
    end
  endtask

  // One request held in DRAIN, then six pulses: four fill the queue, the last two drop
  task automatic test_overflow();
    logic [14:0] id;
    int          cyc;
    quiesced = 1'b0;
    exp_q.delete(); exp_cyc_q.delete();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({1'b1, 3'd1, 11'(10 + i)});
      exp_cyc_q.push_back(31 + 19 * i);
    end
    req_valid = 1'b1; req_pf = 3'd1; req_vfa = 1'b1; req_vf = 11'd10;
    for (int k = 1; k <= 120; k++) begin
      step();
      if (k == 24) begin
        checks++;
        if (err_ovf !== 1'b0) begin
          errors++;
          $display("FAIL ovf_before_drop: got %b expected 0", err_ovf);
        end
      end
      if (k == 26) begin
        checks++;
        if (err_ovf !== 1'b1) begin
          errors++;
          $display("FAIL ovf_after_drop: got %b expected 1", err_ovf);
        end
      end
      if (k >= 20 && k <= 25) begin
        req_valid = 1'b1; req_vf = 11'(k - 9);
      end else begin
        req_valid = 1'b0;
      end
      if (k == 30) quiesced = 1'b1;
      if (rsp_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL ovf_unexpected_rsp at cycle %0d: got id=%h expected none", k,
                   {rsp_vfa, rsp_pf, rsp_vf});
        end else begin
          id = exp_q.pop_front();
          cyc = exp_cyc_q.pop_front();
          if ({rsp_vfa, rsp_pf, rsp_vf} !== id || k != cyc) begin
            errors++;
            $display("FAIL ovf_rsp: got id=%h at cycle %0d expected id=%h at cycle %0d",
                     {rsp_vfa, rsp_pf, rsp_vf}, k, id, cyc);
          end
        end
      end
    end
    req_vf = '0; req_pf = '0; req_vfa = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL ovf_missing: got %0d responses outstanding expected 0", exp_q.size());
    end
  endtask

  // A clear alone drops the flag; a clear together with a new drop keeps it
  task automatic test_clr_priority();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++;
    if (err_ovf !== 1'b0) begin
      errors++;
      $display("FAIL clr_alone: got %b expected 0", err_ovf);
    end
    quiesced = 1'b0;
    req_valid = 1'b1; req_pf = 3'd0; req_vfa = 1'b0; req_vf = 11'd20;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k <= 5) req_vf = 11'(20 + k);
      if (k == 6) begin
        checks++;
        if (err_ovf !== 1'b1) begin
          errors++;
          $display("FAIL clr_setup_ovf: got %b expected 1", err_ovf);
        end
        req_valid = 1'b0;
        err_clr = 1'b0;
      end
      if (k == 7) begin
        req_valid = 1'b1; err_clr = 1'b1;
      end
      if (k == 8) begin
        checks++;
        if (err_ovf !== 1'b1) begin
          errors++;
          $display("FAIL clr_vs_overflow: got %b expected 1", err_ovf);
        end
        req_valid = 1'b0; err_clr = 1'b0;
      end
      if (k == 9) err_clr = 1'b1;
      if (k == 10) begin
        err_clr = 1'b0;
        checks++;
        if (err_ovf !== 1'b0) begin
          errors++;
          $display("FAIL clr_after: got %b expected 0", err_ovf);
        end
      end
    end
    req_vf = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Reset in the 5th ASSERT cycle with two requests queued, then a fresh request
  task automatic test_reset_mid();
    int stray = 0;
    quiesced = 1'b0;
    req_valid = 1'b1; req_pf = 3'd3; req_vfa = 1'b0; req_vf = 11'd30;
    for (int k = 1; k <= 75; k++) begin
      step();
      if (rsp_valid === 1'b1 && k != 69) stray++;
      if (k <= 2) req_vf = 11'(30 + k);
      if (k == 3) begin
        req_valid = 1'b0; req_vf = '0; req_pf = '0;
      end
      if (k == 6) begin
        checks++;
        if (rst_valid !== 1'b1 || rst_vf !== 11'd30 || rst_pf !== 3'd3) begin
          errors++;
          $display("FAIL mid_pre_reset: got valid=%b pf=%0d vf=%0d expected 1 3 30",
                   rst_valid, rst_pf, rst_vf);
        end
        reset = 1'b1;
      end
      if (k == 7) begin
        reset = 1'b0;
        quiesced = 1'b1;
        checks++;
        if (rst_valid !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL mid_after_reset: got rst_valid=%b busy=%b expected 0 0", rst_valid, busy);
        end
      end
      if (k == 45) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL mid_busy_idle: got %b expected 0", busy);
        end
      end
      if (k == 50) begin
        req_valid = 1'b1; req_pf = 3'd4; req_vfa = 1'b1; req_vf = 11'h055;
      end
      if (k == 51) begin
        req_valid = 1'b0; req_pf = '0; req_vfa = 1'b0; req_vf = '0;
      end
      if (k == 52) begin
        checks++;
        if (rst_valid !== 1'b1 || {rst_vfa, rst_pf, rst_vf} !== {1'b1, 3'd4, 11'h055}) begin
          errors++;
          $display("FAIL mid_new_func_rst: got valid=%b id=%h expected 1 %h", rst_valid,
                   {rst_vfa, rst_pf, rst_vf}, {1'b1, 3'd4, 11'h055});
        end
      end
      if (k == 69) begin
        checks++;
        if (rsp_valid !== 1'b1 || {rsp_vfa, rsp_pf, rsp_vf} !== {1'b1, 3'd4, 11'h055}) begin
          errors++;
          $display("FAIL mid_new_rsp: got valid=%b id=%h expected 1 %h", rsp_valid,
                   {rsp_vfa, rsp_pf, rsp_vf}, {1'b1, 3'd4, 11'h055});
        end
      end
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL mid_stray_rsp: got %0d responses expected 0", stray);
    end
  endtask

  // DRAIN_TIMEOUT=8: forced response at T+27, then quiesce exactly at the limit
  task automatic test_timeout();
    t_quiesced = 1'b0;
    t_req_valid = 1'b1; t_req_pf = 3'd5; t_req_vfa = 1'b1; t_req_vf = 11'd7;
    for (int k = 1; k <= 31; k++) begin
      step();
      if (k == 1) begin
        t_req_valid = 1'b0; t_req_pf = '0; t_req_vfa = 1'b0; t_req_vf = '0;
      end
      checks++;
      if (t_rsp_valid !== (k == 27)) begin
        errors++;
        $display("FAIL to_rsp_timing at T+%0d: got %b expected %b", k, t_rsp_valid, (k == 27));
      end
      if (k == 17 || k == 18) begin
        checks++;
        if (t_rst_valid !== (k == 17) || {t_rst_vfa, t_rst_pf, t_rst_vf} !==
            ((k == 17) ? {1'b1, 3'd5, 11'd7} : 15'd0)) begin
          errors++;
          $display("FAIL to_func_rst at T+%0d: got valid=%b id=%h", k, t_rst_valid,
                   {t_rst_vfa, t_rst_pf, t_rst_vf});
        end
      end
      if (k == 26) begin
        checks++;
        if (t_err_to !== 1'b0) begin
          errors++;
          $display("FAIL to_err_early: got %b expected 0", t_err_to);
        end
      end
      if (k == 27) begin
        checks++;
        if ({t_rsp_vfa, t_rsp_pf, t_rsp_vf} !== {1'b1, 3'd5, 11'd7} || t_err_to !== 1'b1) begin
          errors++;
          $display("FAIL to_rsp: got id=%h err=%b expected id=%h err=1",
                   {t_rsp_vfa, t_rsp_pf, t_rsp_vf}, t_err_to, {1'b1, 3'd5, 11'd7});
        end
      end
      if (k == 29) t_err_clr = 1'b1;
      if (k == 30) t_err_clr = 1'b0;
      if (k == 31) begin
        checks++;
        if (t_err_to !== 1'b0 || t_busy !== 1'b0) begin
          errors++;
          $display("FAIL to_clr: got err=%b busy=%b expected 0 0", t_err_to, t_busy);
        end
      end
    end
    t_req_valid = 1'b1; t_req_pf = 3'd1; t_req_vfa = 1'b0; t_req_vf = 11'd8;
    for (int k = 1; k <= 29; k++) begin
      step();
      if (k == 1) begin
        t_req_valid = 1'b0; t_req_pf = '0; t_req_vf = '0;
      end
      if (k == 26) t_quiesced = 1'b1;
      checks++;
      if (t_rsp_valid !== (k == 27)) begin
        errors++;
        $display("FAIL to_edge_rsp at T+%0d: got %b expected %b", k, t_rsp_valid, (k == 27));
      end
      if (k == 28) begin
        checks++;
        if (t_err_to !== 1'b0) begin
          errors++;
          $display("FAIL to_edge_quiesce_wins: got err=%b expected 0", t_err_to);
        end
      end
    end
    t_quiesced = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_clr_priority();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
